// File: rtl/seq_checker.sv
// seq_checker: run-time monitor confirming each sampled state is the previous sample plus one
module seq_checker #(
    parameter int WIDTH    = 3,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [WIDTH-1:0]  state_in,
    input  logic              clear,
    output logic              locked,
    output logic              err_flag,
    output logic [ERR_W-1:0]  err_count,
    output logic [WIDTH-1:0]  last_bad,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count
);
    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

    state_t             state, state_d;
    logic [WIDTH-1:0]   prev, prev_d, last_bad_d;
    logic [3:0]         good_run, good_run_d, run_inc;
    logic               err_flag_d, wrap_pulse_d, correct;
    logic [ERR_W-1:0]   err_count_d;
    logic [WRAP_W-1:0]  wrap_count_d;

    assign correct = state_in == prev + WIDTH'(1);
    assign run_inc = good_run + 4'd1;
    assign locked  = state == S_LOCK;

    // next-state and status update; clear wins over a simultaneous sample
    always_comb begin
        state_d      = state;
        prev_d       = prev;
        good_run_d   = good_run;
        err_flag_d   = err_flag;
        err_count_d  = err_count;
        last_bad_d   = last_bad;
        wrap_pulse_d = 1'b0;
        wrap_count_d = wrap_count;
        if (clear) begin
            state_d      = S_IDLE;
            prev_d       = '0;
            good_run_d   = '0;
            err_flag_d   = 1'b0;
            err_count_d  = '0;
            last_bad_d   = '0;
            wrap_count_d = '0;
        end else if (sample_en) begin
            prev_d = state_in;
            case (state)
                S_IDLE: begin
                    good_run_d = '0;
                    state_d    = S_ACQ;
                end
                S_ACQ: begin
                    good_run_d = correct ? run_inc : '0;
                    if (correct && run_inc == 4'(LOCK_CNT)) state_d = S_LOCK;
                end
                S_LOCK: begin
                    if (correct) begin
                        if (state_in == '0) begin
                            wrap_pulse_d = 1'b1;
                            wrap_count_d = wrap_count + WRAP_W'(1);
                        end
                    end else begin
                        err_flag_d  = 1'b1;
                        err_count_d = (&err_count) ? err_count : err_count + ERR_W'(1);
                        last_bad_d  = state_in;
                        good_run_d  = '0;
                        state_d     = S_ACQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // state and status registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            prev       <= '0;
            good_run   <= '0;
            err_flag   <= 1'b0;
            err_count  <= '0;
            last_bad   <= '0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
        end else begin
            state      <= state_d;
            prev       <= prev_d;
            good_run   <= good_run_d;
            err_flag   <= err_flag_d;
            err_count  <= err_count_d;
            last_bad   <= last_bad_d;
            wrap_pulse <= wrap_pulse_d;
            wrap_count <= wrap_count_d;
        end
    end
endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: table-driven and directed checks of the sequence checker
module tb_seq_checker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [2:0]  state_in = '0;
    logic        clear = 1'b0;
    logic        locked, err_flag, wrap_pulse;
    logic [7:0]  err_count;
    logic [2:0]  last_bad;
    logic [15:0] wrap_count;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic        c;
        logic        e;
        logic [2:0]  s;
        logic        l;
        logic        ef;
        logic [7:0]  ec;
        logic [2:0]  lb;
        logic        wp;
        logic [15:0] wc;
    } vec_t;

    vec_t vecs[$];

    seq_checker dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .state_in(state_in), .clear(clear),
        .locked(locked), .err_flag(err_flag), .err_count(err_count), .last_bad(last_bad),
        .wrap_pulse(wrap_pulse), .wrap_count(wrap_count)
    );

    always #5 clk = ~clk;

    task automatic add(input logic c, e, input int s, input logic l, ef, input int ec, lb,
                       input logic wp, input int wc);
        vec_t v;
        v.c = c; v.e = e; v.s = 3'(s); v.l = l; v.ef = ef; v.ec = 8'(ec);
        v.lb = 3'(lb); v.wp = wp; v.wc = 16'(wc);
        vecs.push_back(v);
    endtask

    task automatic step(input logic c, e, input int s);
        clear = c; sample_en = e; state_in = 3'(s);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic l, ef, input int ec, lb,
                       input logic wp, input int wc);
        checks++;
        if ({locked, err_flag, err_count, last_bad, wrap_pulse, wrap_count} !==
            {l, ef, 8'(ec), 3'(lb), wp, 16'(wc)}) begin
            errors++;
            $display("FAIL %s: got l=%b ef=%b ec=%0d lb=%0d wp=%b wc=%0d want l=%b ef=%b ec=%0d lb=%0d wp=%b wc=%0d",
                     name, locked, err_flag, err_count, last_bad, wrap_pulse, wrap_count,
                     l, ef, ec, lb, wp, wc);
        end
    endtask

    initial begin
        int v;
        for (int i = 0; i <= 32; i++)
            add(0, 1, i % 8, i >= 2, 0, 0, 0, i >= 8 && i % 8 == 0, i / 8);
        add(0, 1, 1, 1, 0, 0, 0, 0, 4);
        add(0, 1, 2, 1, 0, 0, 0, 0, 4);
        add(0, 1, 3, 1, 0, 0, 0, 0, 4);
        add(0, 1, 4, 1, 0, 0, 0, 0, 4);
        add(0, 1, 4, 0, 1, 1, 4, 0, 4);
        add(0, 1, 5, 0, 1, 1, 4, 0, 4);
        add(0, 1, 6, 1, 1, 1, 4, 0, 4);
        add(0, 1, 7, 1, 1, 1, 4, 0, 4);
        add(0, 1, 0, 1, 1, 1, 4, 1, 5);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 8; i++) begin
            add(0, 1, i % 8, i >= 2, 0, 0, 0, i == 8, i == 8 ? 1 : 0);
            add(0, 0, i % 8, i >= 2, 0, 0, 0, 0, i == 8 ? 1 : 0);
        end
        add(1, 1, 5, 0, 0, 0, 0, 0, 0);
        add(0, 1, 6, 0, 0, 0, 0, 0, 0);
        add(0, 1, 7, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].c, vecs[i].e, vecs[i].s);
            chk($sformatf("vec%0d", i), vecs[i].l, vecs[i].ef, vecs[i].ec, vecs[i].lb,
                vecs[i].wp, vecs[i].wc);
        end

        v = 1;
        for (int k = 0; k < 300; k++) begin
            step(0, 1, v);
            chk($sformatf("sat_err%0d", k), 0, 1, k + 1 > 255 ? 255 : k + 1, v, 0, 0);
            step(0, 1, (v + 1) % 8);
            step(0, 1, (v + 2) % 8);
            chk($sformatf("sat_relock%0d", k), 1, 1, k + 1 > 255 ? 255 : k + 1, v, 0, 0);
            v = (v + 2) % 8;
        end
        step(1, 0, 0);
        chk("sat_clear", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i <= 24; i++) step(0, 1, i % 8);
        chk("pre_reset", 1, 0, 0, 0, 1, 3);
        sample_en = 1'b0;
        #3 rst_n = 1'b0;
        #1 chk("async_reset", 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        step(0, 1, 0);
        chk("relock0", 0, 0, 0, 0, 0, 0);
        step(0, 1, 1);
        chk("relock1", 0, 0, 0, 0, 0, 0);
        step(0, 1, 2);
        chk("relock2", 1, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
